hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 80 ++++++++
 tb/tb_hazard_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: two-slot writer scoreboard (EX, MEM), load-use
// stall, two-bubble taken-branch flush, and registered EX operand forwarding.
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [5:0] id_rs,
    input  logic [5:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [5:0] id_rd,
    input  logic       id_wr,
    input  logic       id_is_load,
    input  logic       ex_br_taken,
    output logic       pc_sel,
    output logic       stall,
    output logic       flush,
    output logic       fwd_a_sel,
    output logic       fwd_b_sel
);

    typedef struct packed {
        logic       valid;
        logic [5:0] rd;
        logic       wr;
        logic       is_load;
    } slot_t;

    typedef enum logic {RUN = 1'b0, FLUSH2 = 1'b1} state_t;

    state_t state;
    slot_t  ex_slot, mem_slot;
    logic   stall_q;
    logic   ex_match, mem_match, load_use, issue;
    logic   fwd_a_nxt, fwd_b_nxt;

    // r0 is hardwired zero, so a write to it never creates a dependency.
    function automatic logic writer(input slot_t s);
        return s.valid & s.wr & (s.rd != 6'd0);
    endfunction

    always_comb begin
        ex_match  = writer(ex_slot);
        mem_match = writer(mem_slot);
        load_use  = (state == RUN) & id_valid & ex_match & ex_slot.is_load &
                    ((id_uses_rs & (id_rs == ex_slot.rd)) |
                     (id_uses_rt & (id_rt == ex_slot.rd)));
        pc_sel    = !rst & (state == RUN) & ex_br_taken;
        flush     = !rst & ((state == FLUSH2) | ex_br_taken);
        stall     = !rst & load_use & !flush;
        issue     = id_valid & !stall & !flush;
        // The MEM-slot load only forwards to the instruction retried right
        // after its load-use stall; anything older is covered by write-through.
        fwd_a_nxt = issue & id_uses_rs &
                    ((ex_match & !ex_slot.is_load & (id_rs == ex_slot.rd)) |
                     (stall_q & mem_match & mem_slot.is_load & (id_rs == mem_slot.rd)));
        fwd_b_nxt = issue & id_uses_rt &
                    ((ex_match & !ex_slot.is_load & (id_rt == ex_slot.rd)) |
                     (stall_q & mem_match & mem_slot.is_load & (id_rt == mem_slot.rd)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            ex_slot   <= '0;
            mem_slot  <= '0;
            stall_q   <= 1'b0;
            fwd_a_sel <= 1'b0;
            fwd_b_sel <= 1'b0;
        end else begin
            state     <= (state == RUN && ex_br_taken) ? FLUSH2 : RUN;
            mem_slot  <= ex_slot;
            ex_slot   <= issue ? slot_t'{1'b1, id_rd, id_wr, id_is_load} : '0;
            stall_q   <= stall;
            fwd_a_sel <= fwd_a_nxt;
            fwd_b_sel <= fwd_b_nxt;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: reset, forwarding, load-use,
// branch flush, priority, r0 and reset-abort scenarios.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [5:0] id_rs, id_rt, id_rd;
    logic       id_uses_rs, id_uses_rt, id_wr, id_is_load;
    logic       ex_br_taken;
    logic       pc_sel, stall, flush, fwd_a_sel, fwd_b_sel;

    int tests  = 0;
    int failed = 0;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
        .pc_sel(pc_sel), .stall(stall), .flush(flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [5:0] rs, input logic urs,
                          input logic [5:0] rt, input logic urt,
                          input logic [5:0] rd, input logic wr, input logic ld);
        id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_rd = rd; id_wr = wr; id_is_load = ld;
        #1;
    endtask

    task automatic idle(input int n);
        ex_br_taken = 1'b0;
        set_id(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_br_taken = 1'b1;
        set_id(1'b1, 6'd5, 1'b1, 6'd5, 1'b1, 6'd5, 1'b1, 1'b1);
        tests++; if (pc_sel !== 1'b0) begin failed++; $display("FAIL reset_pc_sel got %b exp 0", pc_sel); end
        tests++; if (flush !== 1'b0) begin failed++; $display("FAIL reset_flush got %b exp 0", flush); end
        tests++; if (stall !== 1'b0) begin failed++; $display("FAIL reset_stall got %b exp 0", stall); end
        tick(); tick();
        tests++; if ({fwd_a_sel, fwd_b_sel} !== 2'b00) begin failed++; $display("FAIL reset_fwd got %b exp 00", {fwd_a_sel, fwd_b_sel}); end
        tests++; if ({dut.ex_slot.valid, dut.mem_slot.valid} !== 2'b00) begin failed++; $display("FAIL reset_slots got %b exp 00", {dut.ex_slot.valid, dut.mem_slot.valid}); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_fwd_alu();
        set_id(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd5, 1'b1, 1'b0);   // add r5,r1,r2
        tick();
        set_id(1'b1, 6'd5, 1'b1, 6'd1, 1'b1, 6'd7, 1'b1, 1'b0);   // add r7,r5,r1
        tests++; if (stall !== 1'b0) begin failed++; $display("FAIL alu_stall got %b exp 0", stall); end
        tick();
        idle(0);
        tests++; if (fwd_a_sel !== 1'b1) begin failed++; $display("FAIL alu_fwd_a got %b exp 1", fwd_a_sel); end
        tests++; if (fwd_b_sel !== 1'b0) begin failed++; $display("FAIL alu_fwd_b got %b exp 0", fwd_b_sel); end
        tick();
        tests++; if (fwd_a_sel !== 1'b0) begin failed++; $display("FAIL alu_fwd_a_clear got %b exp 0", fwd_a_sel); end
        idle(2);
    endtask

    task automatic test_load_use();
        set_id(1'b1, 6'd2, 1'b1, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1);   // lw r5,0(r2)
        tick();
        set_id(1'b1, 6'd1, 1'b1, 6'd5, 1'b1, 6'd7, 1'b1, 1'b0);   // add r7,r1,r5
        tests++; if (stall !== 1'b1) begin failed++; $display("FAIL lu_stall got %b exp 1", stall); end
        tests++; if (flush !== 1'b0) begin failed++; $display("FAIL lu_flush got %b exp 0", flush); end
        tick();
        tests++; if (stall !== 1'b0) begin failed++; $display("FAIL lu_stall_once got %b exp 0", stall); end
        tests++; if (dut.ex_slot.valid !== 1'b0) begin failed++; $display("FAIL lu_bubble got %b exp 0", dut.ex_slot.valid); end
        tests++; if (fwd_b_sel !== 1'b0) begin failed++; $display("FAIL lu_fwd_b_stalled got %b exp 0", fwd_b_sel); end
        tick();
        idle(0);
        tests++; if ({fwd_a_sel, fwd_b_sel} !== 2'b01) begin failed++; $display("FAIL lu_retry_fwd got %b exp 01", {fwd_a_sel, fwd_b_sel}); end
        tests++; if (dut.ex_slot.rd !== 6'd7) begin failed++; $display("FAIL lu_retry_issue got %0d exp 7", dut.ex_slot.rd); end
        idle(2);
    endtask

    task automatic test_branch();
        ex_br_taken = 1'b1;
        set_id(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 1'b1, 1'b0);
        tests++; if ({pc_sel, flush, stall} !== 3'b110) begin failed++; $display("FAIL br_n got %b exp 110", {pc_sel, flush, stall}); end
        tick();
        set_id(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd8, 1'b1, 1'b0);   // ex_br_taken still 1: ignored
        tests++; if ({pc_sel, flush} !== 2'b01) begin failed++; $display("FAIL br_n1 got %b exp 01", {pc_sel, flush}); end
        tests++; if (dut.ex_slot.valid !== 1'b0) begin failed++; $display("FAIL br_bubble1 got %b exp 0", dut.ex_slot.valid); end
        tick();
        ex_br_taken = 1'b0;
        set_id(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd4, 1'b1, 1'b0);
        tests++; if ({pc_sel, flush} !== 2'b00) begin failed++; $display("FAIL br_n2 got %b exp 00", {pc_sel, flush}); end
        tests++; if ({dut.ex_slot.valid, dut.mem_slot.valid} !== 2'b00) begin failed++; $display("FAIL br_bubble2 got %b exp 00", {dut.ex_slot.valid, dut.mem_slot.valid}); end
        tick();
        tests++; if ({dut.ex_slot.valid, dut.ex_slot.rd} !== {1'b1, 6'd4}) begin failed++; $display("FAIL br_resume got %b exp 1000100", {dut.ex_slot.valid, dut.ex_slot.rd}); end
        idle(2);
    endtask

    task automatic test_load_branch();
        set_id(1'b1, 6'd2, 1'b1, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1);
        tick();
        ex_br_taken = 1'b1;
        set_id(1'b1, 6'd5, 1'b1, 6'd1, 1'b1, 6'd7, 1'b1, 1'b0);
        tests++; if ({stall, flush, pc_sel} !== 3'b011) begin failed++; $display("FAIL lb_prio got %b exp 011", {stall, flush, pc_sel}); end
        tick();
        ex_br_taken = 1'b0;
        tests++; if (dut.state !== 1'b1) begin failed++; $display("FAIL lb_state got %b exp 1", dut.state); end
        tests++; if ({stall, flush, pc_sel} !== 3'b010) begin failed++; $display("FAIL lb_flush2 got %b exp 010", {stall, flush, pc_sel}); end
        idle(3);
    endtask

    task automatic test_r0();
        set_id(1'b1, 6'd1, 1'b1, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1);   // lw r0
        tick();
        set_id(1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0);   // add r0,r0,r0
        tests++; if (stall !== 1'b0) begin failed++; $display("FAIL r0_stall got %b exp 0", stall); end
        tick();
        set_id(1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 6'd9, 1'b1, 1'b0);   // add r9,r0,r0
        tests++; if (stall !== 1'b0) begin failed++; $display("FAIL r0_stall2 got %b exp 0", stall); end
        tick();
        idle(0);
        tests++; if ({fwd_a_sel, fwd_b_sel} !== 2'b00) begin failed++; $display("FAIL r0_fwd got %b exp 00", {fwd_a_sel, fwd_b_sel}); end
        idle(2);
    endtask

    task automatic test_reset_flush2();
        set_id(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd5, 1'b1, 1'b0);
        tick();
        ex_br_taken = 1'b1;
        set_id(1'b1, 6'd5, 1'b1, 6'd5, 1'b1, 6'd6, 1'b1, 1'b0);
        tick();
        ex_br_taken = 1'b0;
        rst = 1'b1;
        #1;
        tests++; if (flush !== 1'b0) begin failed++; $display("FAIL rf_flush_in_rst got %b exp 0", flush); end
        tick();
        rst = 1'b0;
        idle(0);
        tests++; if (flush !== 1'b0) begin failed++; $display("FAIL rf_flush_after got %b exp 0", flush); end
        tests++; if ({fwd_a_sel, fwd_b_sel} !== 2'b00) begin failed++; $display("FAIL rf_fwd got %b exp 00", {fwd_a_sel, fwd_b_sel}); end
        tests++; if ({dut.state, dut.ex_slot.valid, dut.mem_slot.valid} !== 3'b000) begin failed++; $display("FAIL rf_state_slots got %b exp 000", {dut.state, dut.ex_slot.valid, dut.mem_slot.valid}); end
        idle(2);
    endtask

    initial begin
        rst = 1'b1;
        idle(0);
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_branch();
        test_load_branch();
        test_r0();
        test_reset_flush2();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
